// File: rtl/mr_shift_unit_pkg.sv
// Shared definitions for the multiplier-register (MR) shift unit: control bit
// defaults, FSM state encoding and the step-counter width helper.
package mr_pkg;

  localparam int MR_CLR_BIT = 21;
  localparam int MR_LD_BIT  = 20;
  localparam int MR_SHR_BIT = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mr_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mr_shift_unit_step_counter.sv
// Shift-step counter: clears on request, counts enabled steps and saturates at
// WIDTH; last_step flags the step that completes the sequence.
module mr_step_counter
  import mr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last_step
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last_step = (cnt == CNT_LAST);

endmodule

// File: rtl/mr_shift_unit.sv
// Multiplier register for the shift-add / Booth multiply sequence: holds the
// multiplier, takes ACC[0] into its MSB on each shift and tracks completion.
module mr_shift_unit
  import mr_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CTRL_W  = 32,
  parameter int CLR_BIT = MR_CLR_BIT,
  parameter int LD_BIT  = MR_LD_BIT,
  parameter int SHR_BIT = MR_SHR_BIT,
  parameter int BOOTH   = 1,
  parameter int CW      = cnt_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_signal,
  input  logic [WIDTH-1:0]  mr_in,
  input  logic              acc_lsb,
  output logic [WIDTH-1:0]  mr_out,
  output logic [1:0]        booth_pair,
  output logic [CW-1:0]     step_cnt,
  output logic              busy,
  output logic              done
);

  logic             clr;
  logic             ld;
  logic             shr;
  logic             shift_en;
  logic             last_step;
  logic [WIDTH-1:0] mr;
  logic             q_1;
  mr_state_e        state;
  mr_state_e        state_nxt;
  logic             unused_ctrl;

  // Priority CLR > LD > SHR is resolved here, once, for every consumer.
  assign clr      = control_signal[CLR_BIT];
  assign ld       = control_signal[LD_BIT] & ~clr;
  assign shr      = control_signal[SHR_BIT] & ~clr & ~ld;
  assign shift_en = shr & (state == RUN);

  assign unused_ctrl = ^control_signal;

  mr_step_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr | ld),
    .en        (shift_en),
    .cnt       (step_cnt),
    .last_step (last_step)
  );

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (ld) begin
      state_nxt = RUN;
    end else if (shift_en && last_step) begin
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mr  <= '0;
      q_1 <= 1'b0;
    end else if (clr) begin
      mr  <= '0;
      q_1 <= 1'b0;
    end else if (ld) begin
      mr  <= mr_in;
      q_1 <= 1'b0;
    end else if (shift_en) begin
      mr  <= {acc_lsb, mr[WIDTH-1:1]};
      q_1 <= mr[0];
    end
  end

  assign mr_out = mr;

  // Plain shift-add only needs the current multiplier bit, so q_1 drops out.
  generate
    if (BOOTH != 0) begin : g_booth
      assign booth_pair = {mr[0], q_1};
    end else begin : g_plain
      assign booth_pair = {1'b0, mr[0]};
    end
  endgenerate

endmodule

// File: tb/tb_mr_shift_unit.sv
// Scoreboard bench for mr_shift_unit: a behavioural model predicts each cycle's
// outputs, the prediction is queued at drive time and popped after the edge.
module tb_mr_shift_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] control_signal = '0;
  logic [15:0] mr_in = '0;
  logic        acc_lsb = 1'b0;
  logic [15:0] mr_out;
  logic [1:0]  booth_pair;
  logic [4:0]  step_cnt;
  logic        busy;
  logic        done;

  logic [31:0] ctrl8 = '0;
  logic [7:0]  mr_in8 = '0;
  logic        acc8 = 1'b0;
  logic [7:0]  mr_out8;
  logic [1:0]  booth8;
  logic [3:0]  cnt8;
  logic        busy8;
  logic        done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mr_shift_unit dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .mr_in          (mr_in),
    .acc_lsb        (acc_lsb),
    .mr_out         (mr_out),
    .booth_pair     (booth_pair),
    .step_cnt       (step_cnt),
    .busy           (busy),
    .done           (done)
  );

  mr_shift_unit #(.WIDTH(8), .BOOTH(0)) dut8 (
    .clk            (clk),
    .rst            (rst),
    .control_signal (ctrl8),
    .mr_in          (mr_in8),
    .acc_lsb        (acc8),
    .mr_out         (mr_out8),
    .booth_pair     (booth8),
    .step_cnt       (cnt8),
    .busy           (busy8),
    .done           (done8)
  );

  typedef struct packed {
    logic [15:0] mr;
    logic [1:0]  bp;
    logic [4:0]  cnt;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [15:0] m_mr  = '0;
  logic        m_q1  = 1'b0;
  logic [4:0]  m_cnt = '0;
  int          m_st  = 0;  // 0 idle, 1 run, 2 done

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mr = '0; m_q1 = 1'b0; m_cnt = '0; m_st = 0;
  endtask

  task automatic model_step(input logic c, input logic l, input logic s,
                            input logic [15:0] din, input logic a);
    if (c) begin
      model_reset();
    end else if (l) begin
      m_mr = din; m_q1 = 1'b0; m_cnt = '0; m_st = 1;
    end else if (s && m_st == 1) begin
      m_q1 = m_mr[0];
      m_mr = {a, m_mr[15:1]};
      if (m_cnt == 5'd15) m_st = 2;
      m_cnt = m_cnt + 5'd1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mr   = m_mr;
    e.bp   = {m_mr[0], m_q1};
    e.cnt  = m_cnt;
    e.busy = (m_st == 1);
    e.done = (m_st == 2);
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_mr"},   32'(mr_out),     32'(e.mr));
    chk({tag, "_bp"},   32'(booth_pair), 32'(e.bp));
    chk({tag, "_cnt"},  32'(step_cnt),   32'(e.cnt));
    chk({tag, "_busy"}, 32'(busy),       32'(e.busy));
    chk({tag, "_done"}, 32'(done),       32'(e.done));
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic cycle(input string tag, input logic c, input logic l, input logic s,
                       input logic [15:0] din, input logic a);
    @(negedge clk);
    control_signal = '0;
    control_signal[21] = c;
    control_signal[20] = l;
    control_signal[22] = s;
    mr_in   = din;
    acc_lsb = a;
    model_step(c, l, s, din, a);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst0_mr", 32'(mr_out), 32'h0);
    chk("rst0_bp", 32'(booth_pair), 32'h0);
    chk("rst0_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Async reset mid-sequence
    cycle("r_ld", 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b0);
    for (int i = 0; i < 3; i++) cycle("r_shr", 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    @(negedge clk);
    control_signal = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_mr", 32'(mr_out), 32'h0);
    chk("arst_cnt", 32'(step_cnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_bp", 32'(booth_pair), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Full 16-step sequence
    cycle("t2_ld", 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b0);
    chk("t2_bp_first", 32'(booth_pair), 32'h2);
    for (int i = 0; i < 16; i++) begin
      chk("t2_busy_pre", 32'(busy), 32'h1);
      cycle("t2_shr", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    end
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_cnt", 32'(step_cnt), 32'd16);
    chk("t2_mr", 32'(mr_out), 32'h0);

    // Extra SHR while DONE
    for (int i = 0; i < 5; i++) cycle("t5_hold", 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    chk("t5_cnt", 32'(step_cnt), 32'd16);
    chk("t5_done", 32'(done), 32'h1);

    // Priority CLR > LD > SHR
    cycle("t3_ld", 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0);
    cycle("t3_all", 1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1);
    chk("t3_mr", 32'(mr_out), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    cycle("t3_ld2", 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0);
    chk("t3_mr2", 32'(mr_out), 32'h0003);
    cycle("t3_ldshr", 1'b0, 1'b1, 1'b1, 16'h8001, 1'b1);

    // ACC LSB fills from the top
    cycle("t4_ld", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle("t4_shr", 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    chk("t4_mr", 32'(mr_out), 32'hF000);
    chk("t4_cnt", 32'(step_cnt), 32'd4);
    chk("t4_busy", 32'(busy), 32'h1);

    // LD mid-RUN restarts
    cycle("t5_ld", 1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b0);
    for (int i = 0; i < 7; i++) cycle("t5_shr", 1'b0, 1'b0, 1'b1, 16'h0, i[0]);
    cycle("t5_reld", 1'b0, 1'b1, 1'b0, 16'h7E81, 1'b0);
    chk("t5_recnt", 32'(step_cnt), 32'd0);
    chk("t5_remr", 32'(mr_out), 32'h7E81);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 15);
      cycle("rnd", r == 0, r == 1, r > 3, 16'($urandom), 1'($urandom));
    end

    // WIDTH=8 plain shift-add build
    @(negedge clk);
    ctrl8 = '0; ctrl8[20] = 1'b1; mr_in8 = 8'h81;
    @(posedge clk); #1;
    chk("t6_bp_ld", 32'(booth8), 32'h1);
    chk("t6_busy", 32'(busy8), 32'h1);
    @(negedge clk);
    ctrl8 = '0; ctrl8[22] = 1'b1; acc8 = 1'b0;
    @(posedge clk); #1;
    chk("t6_mr", 32'(mr_out8), 32'h40);
    chk("t6_bp", 32'(booth8), 32'h0);
    chk("t6_cnt", 32'(cnt8), 32'd1);
    for (int i = 0; i < 7; i++) @(posedge clk);
    #1;
    chk("t6_done", 32'(done8), 32'h1);
    chk("t6_cnt8", 32'(cnt8), 32'd8);
    @(negedge clk);
    ctrl8 = '0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
